// File: rtl/cart_pkg.sv
// -----------------------------------------------------------------------------
// cart_pkg
// Shared cartridge definitions used by cart_sram_upload and its dirty-tracking
// helper: the ioctl index that selects an SRAM save upload, the byte returned
// for addresses outside the SRAM, and the upload fetch FSM state type.
// -----------------------------------------------------------------------------
package cart_pkg;

    // ioctl_index value that selects the battery-backed SRAM upload session.
    localparam logic [7:0] SRAM_SAVE_INDEX = 8'h04;

    // Byte returned for reads beyond the end of the SRAM (undriven bus).
    localparam logic [7:0] OPEN_BUS = 8'hFF;

    // Upload fetch sequence: accept a read, present the address to the
    // SRAM for one cycle, then capture the returned byte.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } upload_state_t;

endpackage

// File: rtl/cart_sram_dirty.sv
// -----------------------------------------------------------------------------
// cart_sram_dirty
// Tracks whether the CPU has modified cartridge SRAM since the last save and
// raises save_req once the SRAM has been quiet for QUIET_CYCLES clocks, so the
// HPS pulls a fresh copy. A save session that sees no CPU writes clears the
// dirty state; writes during the session keep it dirty and restart the quiet
// period.
//
// Ports
//   clk          in  system clock
//   reset        in  synchronous, active-high reset
//   cpu_sram_we  in  one-cycle strobe: CPU wrote SRAM
//   session      in  save upload session currently active (combinational)
//   busy         in  registered session (one cycle behind session)
//   save_req     out request the HPS to perform an SRAM upload
// -----------------------------------------------------------------------------
module cart_sram_dirty
    import cart_pkg::*;
#(
    parameter logic [23:0] QUIET_CYCLES = 24'd3579545
) (
    input  logic clk,
    input  logic reset,
    input  logic cpu_sram_we,
    input  logic session,
    input  logic busy,
    output logic save_req
);

    logic        dirty;
    logic        wrote_during;
    logic [23:0] quiet_cnt;
    logic        session_end;

    // busy still high while session has already dropped marks the last
    // cycle of a save session.
    assign session_end = busy && !session;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge regardless of order.
    always_ff @(posedge clk) begin
        if (reset) begin
            dirty        <= 1'b0;
            wrote_during <= 1'b0;
            quiet_cnt    <= '0;
        end else if (session_end) begin
            // A write landing on the closing cycle still counts as part of
            // the session, so the saved image may already be stale.
            dirty        <= wrote_during || cpu_sram_we;
            wrote_during <= 1'b0;
            quiet_cnt    <= '0;
        end else if (cpu_sram_we) begin
            dirty     <= 1'b1;
            quiet_cnt <= '0;
            if (session) begin
                wrote_during <= 1'b1;
            end
        end else if (dirty && (quiet_cnt < QUIET_CYCLES)) begin
            quiet_cnt <= quiet_cnt + 24'd1;
        end
    end

    // Withdrawn as soon as a session is under way; the HPS is already saving.
    assign save_req = dirty && (quiet_cnt == QUIET_CYCLES) && !busy;

endmodule

// File: rtl/cart_sram_upload.sv
// -----------------------------------------------------------------------------
// cart_sram_upload
// Serves HPS ioctl upload reads of cartridge battery-backed SRAM. Each accepted
// ioctl_rd borrows the shared SRAM port for a fetch and returns the byte on
// ioctl_din, holding ioctl_wait high until the byte is ready. Addresses past the
// SRAM return OPEN_BUS without touching the SRAM. Dirty tracking and the save
// request live in cart_sram_dirty.
//
// Ports
//   clk           in  system clock
//   reset         in  synchronous, active-high reset
//   ioctl_upload  in  HPS upload session active
//   ioctl_index   in  session index (only SAVE_INDEX is served)
//   ioctl_rd      in  one-cycle read strobe from HPS
//   ioctl_addr    in  byte address of requested read
//   ioctl_din     out byte returned to HPS
//   ioctl_wait    out HPS must not issue the next ioctl_rd while high
//   cpu_sram_we   in  one-cycle strobe: CPU wrote SRAM
//   mem_addr      out SRAM read address (valid while mem_own is high)
//   mem_own       out engine owns the SRAM port (mux select)
//   mem_q         in  SRAM read data, registered, one cycle after mem_addr
//   save_req      out request HPS to perform an SRAM upload
//   busy          out save upload session in progress (registered)
// -----------------------------------------------------------------------------
module cart_sram_upload
    import cart_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 13,
    parameter logic [7:0]  SAVE_INDEX   = SRAM_SAVE_INDEX,
    parameter logic [23:0] QUIET_CYCLES = 24'd3579545
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ioctl_upload,
    input  logic [7:0]            ioctl_index,
    input  logic                  ioctl_rd,
    input  logic [24:0]           ioctl_addr,
    output logic [7:0]            ioctl_din,
    output logic                  ioctl_wait,
    input  logic                  cpu_sram_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_own,
    input  logic [7:0]            mem_q,
    output logic                  save_req,
    output logic                  busy
);

    upload_state_t state;
    upload_state_t state_next;
    logic          session;
    logic          accept;
    logic          addr_in_range;
    logic          in_range;

    assign session       = ioctl_upload && (ioctl_index == SAVE_INDEX);
    assign addr_in_range = (ioctl_addr[24:ADDR_WIDTH] == '0);
    // Strobes arriving mid-fetch are dropped; the HPS should be honouring
    // ioctl_wait.
    assign accept        = (state == ST_IDLE) && ioctl_rd && session;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ----------------------------------------------------------- next state
    // A fetch always runs to completion, even if the session drops, so the
    // engine can never be left holding the SRAM port.
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // state_next unassigned, which would infer a latch.
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_ADDR;
            ST_ADDR: state_next = ST_DATA;
            ST_DATA: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        ioctl_wait = 1'b0;
        mem_own    = 1'b0;
        if (state != ST_IDLE) begin
            ioctl_wait = 1'b1;
            // Out-of-range reads never claim the port; the mux stays with
            // the CPU and OPEN_BUS is returned instead.
            mem_own    = in_range;
        end
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr  <= '0;
            in_range  <= 1'b0;
            ioctl_din <= '0;
            busy      <= 1'b0;
        end else begin
            busy <= session;
            if (accept) begin
                mem_addr <= ioctl_addr[ADDR_WIDTH-1:0];
                in_range <= addr_in_range;
            end
            // The SRAM sampled mem_addr on the ADDR edge, so mem_q is now valid.
            if (state == ST_DATA) begin
                ioctl_din <= in_range ? mem_q : OPEN_BUS;
            end
        end
    end

    cart_sram_dirty #(
        .QUIET_CYCLES (QUIET_CYCLES)
    ) u_dirty (
        .clk         (clk),
        .reset       (reset),
        .cpu_sram_we (cpu_sram_we),
        .session     (session),
        .busy        (busy),
        .save_req    (save_req)
    );

endmodule

// File: tb/tb_cart_sram_upload.sv
// -----------------------------------------------------------------------------
// tb_cart_sram_upload
// Self-checking bench for cart_sram_upload (ADDR_WIDTH=13, QUIET_CYCLES=16).
// An SRAM image in the bench answers mem_addr with one cycle of latency. Read
// results come from the image (or 8'hFF past its end) with the fixed fetch
// timing; save_req and busy come from a model that tracks session state and
// the number of cycles since the last event that restarted the quiet period.
// -----------------------------------------------------------------------------
module tb_cart_sram_upload;

    localparam int          AW    = 13;
    localparam int          DEPTH = 1 << AW;
    localparam int          QUIET = 16;

    logic        clk;
    logic        reset;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        cpu_sram_we;
    logic [AW-1:0] mem_addr;
    logic        mem_own;
    logic [7:0]  mem_q;
    logic        save_req;
    logic        busy;

    logic [7:0]  sram [0:DEPTH-1];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    longint cyc = 0;
    longint m_restart = 0;
    bit     m_dirty = 0;
    bit     m_busy = 0;
    bit     m_sess_wrote = 0;
    bit     in_fetch = 0;

    cart_sram_upload #(
        .ADDR_WIDTH   (AW),
        .SAVE_INDEX   (8'h04),
        .QUIET_CYCLES (24'd16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ioctl_upload (ioctl_upload),
        .ioctl_index  (ioctl_index),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (ioctl_din),
        .ioctl_wait   (ioctl_wait),
        .cpu_sram_we  (cpu_sram_we),
        .mem_addr     (mem_addr),
        .mem_own      (mem_own),
        .mem_q        (mem_q),
        .save_req     (save_req),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered SRAM read port.
    always @(posedge clk) mem_q <= sram[mem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Applies one clock edge to the model using the inputs the DUT sampled.
    task automatic model_edge();
        bit sess;
        sess = ioctl_upload && (ioctl_index == 8'h04);
        if (reset) begin
            m_dirty      = 0;
            m_busy       = 0;
            m_sess_wrote = 0;
            m_restart    = cyc;
        end else begin
            if (m_busy && !sess) begin
                // Session closed: stays dirty only if it saw a write.
                m_dirty      = m_sess_wrote || cpu_sram_we;
                m_restart    = cyc;
                m_sess_wrote = 0;
            end else if (cpu_sram_we) begin
                m_dirty   = 1;
                m_restart = cyc;
                if (sess) m_sess_wrote = 1;
            end
            m_busy = sess;
        end
        cyc++;
    endtask

    // One clock: update model at the edge, then check just after it and
    // clear the one-cycle strobes.
    task automatic tick();
        bit exp_save;
        @(posedge clk);
        model_edge();
        #1;
        exp_save = m_dirty && ((cyc - 1 - m_restart) >= QUIET) && !m_busy;
        check("busy", busy, m_busy);
        check("save_req", save_req, exp_save);
        if (!in_fetch) check("own_idle", mem_own, 1'b0);
        ioctl_rd    = 1'b0;
        cpu_sram_we = 1'b0;
    endtask

    // mode 0: plain read, 1: extra ioctl_rd while busy, 2: session drops mid-fetch
    task automatic do_read(input logic [24:0] a, input int mode);
        bit         inr;
        logic [7:0] exp;
        inr = (a < DEPTH);
        exp = inr ? sram[a[AW-1:0]] : 8'hFF;
        in_fetch   = 1;
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        tick();
        check("wait_n1", ioctl_wait, 1'b1);
        check("own_n1", mem_own, inr);
        if (inr) check("mem_addr", mem_addr, a[AW-1:0]);
        if (mode == 1) begin
            ioctl_rd   = 1'b1;
            ioctl_addr = a ^ 25'h1;
        end
        if (mode == 2) ioctl_upload = 1'b0;
        tick();
        check("wait_n2", ioctl_wait, 1'b1);
        check("own_n2", mem_own, inr);
        tick();
        check("wait_n3", ioctl_wait, 1'b0);
        check("own_n3", mem_own, 1'b0);
        check("din", ioctl_din, exp);
        in_fetch = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [24:0] a;
        int          r;

        reset        = 1'b1;
        ioctl_upload = 1'b0;
        ioctl_index  = 8'h00;
        ioctl_rd     = 1'b0;
        ioctl_addr   = '0;
        cpu_sram_we  = 1'b0;
        for (int i = 0; i < DEPTH; i++) sram[i] = 8'($urandom);
        sram[16'h0010] = 8'h5A;

        // Reset state
        tick();
        tick();
        check("rst_din", ioctl_din, 8'h00);
        check("rst_wait", ioctl_wait, 1'b0);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_own", mem_own, 1'b0);
        reset = 1'b0;
        tick();

        // First read of 0x10 (image byte 0x5A)
        ioctl_upload = 1'b1;
        ioctl_index  = 8'h04;
        tick();
        do_read(25'h10, 0);
        check("din_5a", ioctl_din, 8'h5A);

        // Boundaries, out-of-range and a protocol-violating strobe
        do_read(25'h0000000, 0);
        do_read(25'h0001FFF, 0);
        do_read(25'h0002000, 0);
        do_read(25'h1FFFFFF, 0);
        do_read(25'h0000123, 1);
        tick();
        check("idle_after_poke", ioctl_wait, 1'b0);

        // Full sweep with the HPS honouring wait
        for (int i = 0; i < DEPTH; i++) do_read(25'(i), 0);

        // Session drops mid-fetch: fetch still completes
        do_read(25'h0000456, 2);
        tick();
        tick();

        // Quiet timer: single write, then write restarted at cycle 10
        cpu_sram_we = 1'b1;
        tick();
        repeat (20) tick();
        cpu_sram_we = 1'b1;
        tick();
        repeat (10) tick();
        cpu_sram_we = 1'b1;
        tick();
        repeat (20) tick();
        check("save_pending", save_req, 1'b1);

        // Session with a write: dirty survives, save_req returns later
        ioctl_upload = 1'b1;
        tick();
        tick();
        check("save_drop_busy", save_req, 1'b0);
        cpu_sram_we = 1'b1;
        tick();
        repeat (3) tick();
        ioctl_upload = 1'b0;
        tick();
        repeat (20) tick();
        check("save_again", save_req, 1'b1);

        // Clean session: dirty cleared, no save_req
        ioctl_upload = 1'b1;
        repeat (4) tick();
        ioctl_upload = 1'b0;
        repeat (24) tick();
        check("save_cleared", save_req, 1'b0);

        // Write on the closing cycle of a session counts as in-session
        ioctl_upload = 1'b1;
        repeat (3) tick();
        ioctl_upload = 1'b0;
        cpu_sram_we  = 1'b1;
        tick();
        repeat (20) tick();
        check("save_close_write", save_req, 1'b1);

        // Reset while the fetch sits in ADDR
        ioctl_upload = 1'b1;
        tick();
        in_fetch   = 1;
        ioctl_addr = 25'h10;
        ioctl_rd   = 1'b1;
        tick();
        check("pre_rst_wait", ioctl_wait, 1'b1);
        reset = 1'b1;
        tick();
        check("rst_addr_wait", ioctl_wait, 1'b0);
        check("rst_addr_own", mem_own, 1'b0);
        check("rst_addr_din", ioctl_din, 8'h00);
        check("rst_addr_mem", mem_addr, '0);
        in_fetch = 0;
        reset    = 1'b0;
        tick();

        // Foreign index: engine stays inert
        ioctl_index = 8'h05;
        tick();
        ioctl_addr = 25'h10;
        ioctl_rd   = 1'b1;
        tick();
        check("idx5_wait1", ioctl_wait, 1'b0);
        tick();
        check("idx5_wait2", ioctl_wait, 1'b0);
        tick();
        check("idx5_din", ioctl_din, 8'h00);

        // Randomized mix of writes, session toggles, reads and quiet runs
        ioctl_index = 8'h04;
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                ioctl_upload = ~ioctl_upload;
                ioctl_index  = ($urandom_range(0, 3) == 0) ? 8'h05 : 8'h04;
                tick();
            end else if (r < 5 && ioctl_upload && ioctl_index == 8'h04) begin
                a = ($urandom_range(0, 3) == 0) ? 25'($urandom_range(DEPTH, 2 * DEPTH))
                                                : 25'($urandom_range(0, DEPTH - 1));
                do_read(a, ($urandom_range(0, 7) == 0) ? 1 : 0);
            end else if (r == 9) begin
                repeat (18) tick();
            end else begin
                cpu_sram_we = ($urandom_range(0, 3) == 0);
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
